// File: rtl/axis_unpack_if.sv
// Stream bundle for axis_unpack: wide input side (s_*) and word-serial output side (m_*).
// master drives the input beats and consumes words; slave is the unpacker.
interface axis_unpack_if #(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 32
);
    localparam int WPB = BUS_W / WORD_W;

    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [WPB-1:0]    s_keep;
    logic [BUS_W-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [WORD_W-1:0] m_data;

    modport slave (
        input  s_valid, s_last, s_keep, s_data, m_ready,
        output s_ready, m_valid, m_last, m_data
    );

    modport master (
        output s_valid, s_last, s_keep, s_data, m_ready,
        input  s_ready, m_valid, m_last, m_data
    );
endinterface

// File: rtl/axis_unpack.sv
// Wide-beat to one-word-per-beat AXI-Stream unpacker with full throughput.
// Define AXIS_UNPACK_SPARSE_KEEP_EN to emit every kept lane instead of the contiguous prefix.
module axis_unpack #(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    axis_unpack_if.slave    bus,
    output logic            err_empty_last
);
    localparam int WPB = BUS_W / WORD_W;
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t            state;
    logic              run;
    logic [BUS_W-1:0]  data_q;
    logic [WPB-1:0]    mask_q;
    logic              last_q;
    logic [IW-1:0]     idx;
    logic              m_valid;
    logic              m_last;
    logic [WORD_W-1:0] m_data;

    logic [WPB-1:0]    in_mask;
    logic [IW-1:0]     in_first;
    logic [IW:0]       cur_nxt;
    logic [IW:0]       load_nxt;
    logic [IW:0]       adv_nxt;
    logic              acc;
    logic              adv;

    function automatic logic [WPB-1:0] emit_mask(input logic [WPB-1:0] keep);
        logic [WPB-1:0] r;
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        r = keep;
`else
        r[0] = keep[0];
        for (int i = 1; i < WPB; i++)
            r[i] = r[i-1] & keep[i];
`endif
        return r;
    endfunction

    // {found, lane} of the emitted lane following cur
    function automatic logic [IW:0] nxt_of(input logic [WPB-1:0] mask,
                                           input logic [IW-1:0]  cur);
        logic [IW:0] r;
        r = '0;
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        for (int i = WPB - 1; i >= 0; i--)
            if (mask[i] && i > int'(cur))
                r = {1'b1, IW'(i)};
`else
        for (int i = 1; i < WPB; i++)
            if (mask[i] && i == int'(cur) + 1)
                r = {1'b1, IW'(i)};
`endif
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] lane(input logic [BUS_W-1:0] d,
                                               input logic [IW-1:0]    i);
        return WORD_W'(d >> (int'(i) * WORD_W));
    endfunction

    always_comb begin
        in_mask  = emit_mask(bus.s_keep);
        in_first = '0;
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        for (int i = WPB - 1; i >= 0; i--)
            if (in_mask[i])
                in_first = IW'(i);
`endif
    end

    assign cur_nxt  = nxt_of(mask_q, idx);
    assign load_nxt = nxt_of(in_mask, in_first);
    assign adv_nxt  = nxt_of(mask_q, cur_nxt[IW-1:0]);

    // Final lane leaving this cycle frees the holding register for a new beat
    assign bus.s_ready = run &
                         ((state == EMPTY) | (bus.m_ready & ~cur_nxt[IW]));
    assign acc = bus.s_valid & bus.s_ready;
    assign adv = m_valid & bus.m_ready;

    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign bus.m_data  = m_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            run            <= 1'b0;
            data_q         <= '0;
            mask_q         <= '0;
            last_q         <= 1'b0;
            idx            <= '0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_data         <= '0;
            err_empty_last <= 1'b0;
        end else begin
            run            <= 1'b1;
            err_empty_last <= acc & bus.s_last & ~(|in_mask);
            if (acc && (|in_mask)) begin
                state   <= HOLD;
                data_q  <= bus.s_data;
                mask_q  <= in_mask;
                last_q  <= bus.s_last;
                idx     <= in_first;
                m_valid <= 1'b1;
                m_data  <= lane(bus.s_data, in_first);
                m_last  <= bus.s_last & ~load_nxt[IW];
            end else if (adv) begin
                if (cur_nxt[IW]) begin
                    idx    <= cur_nxt[IW-1:0];
                    m_data <= lane(data_q, cur_nxt[IW-1:0]);
                    m_last <= last_q & ~adv_nxt[IW];
                end else begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_unpack.sv
// Scoreboard bench for axis_unpack: directed cases then random packets.
// Build with +define+AXIS_UNPACK_SPARSE_KEEP_EN to check the sparse-keep variant.
module tb_axis_unpack;
    localparam int WORD_W = 8;
    localparam int BUS_W  = 32;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_empty_last;

    axis_unpack_if #(.WORD_W(WORD_W), .BUS_W(BUS_W)) bus ();

    axis_unpack #(.WORD_W(WORD_W), .BUS_W(BUS_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .err_empty_last (err_empty_last)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    err_cnt = 0;
    bit    rnd_done;
    word_t exp_q[$];
    int    cyc_q[$];

    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        word_t w;
        if (err_empty_last) err_cnt++;
        if (bus.m_valid && bus.m_ready) begin
            cyc_q.push_back(cyc);
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("m_data", 32'(bus.m_data), 32'(w.data));
                check("m_last", 32'(bus.m_last), 32'(w.last));
            end
        end
    end

    task automatic push_exp(logic [31:0] d, logic [3:0] k, logic l);
        logic [3:0] m;
        int         hi;
        word_t      w;
        hi = -1;
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        m = k;
`else
        m[0] = k[0];
        for (int i = 1; i < 4; i++) m[i] = m[i-1] & k[i];
`endif
        for (int i = 0; i < 4; i++) if (m[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                w.last = l && (i == hi);
                w.data = d[i*8 +: 8];
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic send(logic [31:0] d, logic [3:0] k, logic l);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_keep  = k;
        bus.s_last  = l;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        check("send_accept", 32'(ok), 32'd1);
        if (ok) push_exp(d, k, l);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20000 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_phase(int npkt, int vpct, int rpct);
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < npkt; p++) begin
                    int rem;
                    rem = $urandom_range(100, 1);
                    while (rem > 0) begin
                        int w;
                        w = $urandom_range(4, 1);
                        if (w > rem) w = rem;
                        for (int t = 0; t < 10000 && $urandom_range(99) >= vpct; t++) begin
                            @(posedge clk);
                            #1;
                        end
                        send($urandom, 4'((1 << w) - 1), rem == w);
                        rem -= w;
                    end
                end
                drain();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.m_ready = ($urandom_range(99) < rpct);
                    @(posedge clk);
                    #1;
                end
            end
        join
    endtask

    initial begin
        int e0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_keep  = '0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_err", 32'(err_empty_last), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_up", 32'(bus.s_ready), 32'd1);

        // single full beat
        bus.m_ready = 1'b1;
        cyc_q.delete();
        send(32'h44332211, 4'hF, 1'b1);
        drain();
        check("t1_words", 32'(cyc_q.size()), 32'd4);
        if (cyc_q.size() == 4) check("t1_span", 32'(cyc_q[3] - cyc_q[0]), 32'd3);

        // back-to-back beats, no bubble
        cyc_q.delete();
        send(32'h04030201, 4'hF, 1'b0);
        send(32'h00000605, 4'h3, 1'b1);
        drain();
        check("t2_words", 32'(cyc_q.size()), 32'd6);
        if (cyc_q.size() == 6) check("t2_span", 32'(cyc_q[5] - cyc_q[0]), 32'd5);

        // output stall mid-beat
        send(32'h44332211, 4'hF, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_m_valid", 32'(bus.m_valid), 32'd1);
            check("t3_m_data", 32'(bus.m_data), 32'h33);
            check("t3_m_last", 32'(bus.m_last), 32'd0);
            check("t3_s_ready", 32'(bus.s_ready), 32'd0);
        end
        bus.m_ready = 1'b1;
        drain();

        // empty last beat
        cyc_q.delete();
        e0 = err_cnt;
        send(32'hDEADBEEF, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t4_no_words", 32'(cyc_q.size()), 32'd0);
        check("t4_m_valid", 32'(bus.m_valid), 32'd0);

        // keep with a gap
        cyc_q.delete();
        send(32'hDDCCBBAA, 4'b1011, 1'b1);
        drain();
`ifdef AXIS_UNPACK_SPARSE_KEEP_EN
        check("t5_words", 32'(cyc_q.size()), 32'd3);
`else
        check("t5_words", 32'(cyc_q.size()), 32'd2);
`endif

        // async reset while holding word 2 of 4
        send(32'h44332211, 4'hF, 1'b1);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_m_valid", 32'(bus.m_valid), 32'd0);
        check("t6_s_ready", 32'(bus.s_ready), 32'd0);
        check("t6_m_last", 32'(bus.m_last), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_ready_low", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t6_ready_up", 32'(bus.s_ready), 32'd1);
        bus.m_ready = 1'b1;
        cyc_q.delete();
        send(32'h0C0B0A09, 4'hF, 1'b1);
        drain();
        check("t6_words", 32'(cyc_q.size()), 32'd4);

        rand_phase(8, 1, 10);
        rand_phase(20, 50, 50);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
